// File: rtl/hamming_weight_sequencer.sv
// Counts set bits over a frame of NUM_Chunks chunks and flags weight > threshold.
// Result valid two cycles after the last chunk; chunks stall on valid gaps, result holds until done_ready.
module hamming_weight_sequencer #(
  parameter int WID_Chunk  = 32,
  parameter int NUM_Chunks = 8,
  parameter int WID_Total  = $clog2(WID_Chunk*NUM_Chunks)+1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 local_HWS_start,
  input  logic [WID_Total-1:0] local_HWS_threshold,
  input  logic [WID_Chunk-1:0] local_HWS_chunk,
  input  logic                 local_HWS_chunk_valid,
  output logic                 HWS_local_chunk_ready,
  output logic [WID_Total-1:0] HWS_local_weight,
  output logic                 HWS_local_over,
  output logic                 HWS_local_done_valid,
  input  logic                 local_HWS_done_ready,
  output logic                 HWS_local_busy
);

  localparam int WID_Cnt = $clog2(WID_Chunk)+1;
  localparam int WID_Idx = (NUM_Chunks > 1) ? $clog2(NUM_Chunks) : 1;
  localparam logic [WID_Idx-1:0] LAST_IDX = WID_Idx'(NUM_Chunks-1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state, state_nxt;
  logic [WID_Total-1:0] acc;
  logic [WID_Total-1:0] thr_q;
  logic [WID_Idx-1:0]   idx;
  logic [WID_Cnt-1:0]   pc_q;
  logic [WID_Cnt-1:0]   pc_cnt;
  logic                 pc_vld;
  logic                 accept;

  BitCounter #(
    .WID_CountRange  (WID_Chunk),
    .WID_CountResult (WID_Cnt)
  ) u_bit_counter (
    .data  (local_HWS_chunk),
    .count (pc_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt             = state;
    HWS_local_chunk_ready = 1'b0;
    HWS_local_done_valid  = 1'b0;
    HWS_local_busy        = (state != IDLE);
    case (state)
      IDLE:  if (local_HWS_start) state_nxt = RUN;
      RUN: begin
        HWS_local_chunk_ready = 1'b1;
        if (local_HWS_chunk_valid && idx == LAST_IDX) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = DONE;
      DONE: begin
        HWS_local_done_valid = 1'b1;
        if (local_HWS_done_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    accept = local_HWS_chunk_valid & HWS_local_chunk_ready;
  end

  // The last popcount lands in acc during DRAIN, so acc is final on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      thr_q  <= '0;
      idx    <= '0;
      pc_q   <= '0;
      pc_vld <= 1'b0;
    end else begin
      pc_vld <= accept;
      if (accept) begin
        pc_q <= pc_cnt;
        idx  <= (idx == LAST_IDX) ? '0 : idx + WID_Idx'(1);
      end
      if (state == IDLE && local_HWS_start) begin
        acc    <= '0;
        idx    <= '0;
        pc_vld <= 1'b0;
        thr_q  <= local_HWS_threshold;
      end else if (pc_vld) begin
        acc <= acc + WID_Total'(pc_q);
      end
    end
  end

  assign HWS_local_weight = HWS_local_done_valid ? acc : '0;
  assign HWS_local_over   = HWS_local_done_valid & (acc > thr_q);

endmodule

module BitCounter #(
  parameter int WID_CountRange  = 32,
  parameter int WID_CountResult = 6
) (
  input  logic [WID_CountRange-1:0]  data,
  output logic [WID_CountResult-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WID_CountRange; i++)
      count = count + WID_CountResult'(data[i]);
  end

endmodule

// File: doc/hamming_weight_sequencer.md
HAMMING_WEIGHT_SEQUENCER -- requirements
Module: hamming_weight_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WID_Chunk, 32, chunk width in bits; limit > 1 and a power of 2.
- NUM_Chunks, 8, chunks per frame; limit >= 1.
- WID_Total, $clog2(WID_Chunk*NUM_Chunks)+1, weight/threshold width; holds WID_Chunk*NUM_Chunks exactly.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Ports, one per line: name, direction, width, meaning.
- clk, in, 1, rising-edge clock.
- rst, in, 1, synchronous active-high reset.
- local_HWS_start, in, 1, frame start pulse; sampled only in IDLE.
- local_HWS_threshold, in, WID_Total, weight limit; latched on accepted start.
- local_HWS_chunk, in, WID_Chunk, frame chunk data.
- local_HWS_chunk_valid, in, 1, chunk valid.
- HWS_local_chunk_ready, out, 1, chunk ready.
- HWS_local_weight, out, WID_Total, frame Hamming weight.
- HWS_local_over, out, 1, weight > latched threshold.
- HWS_local_done_valid, out, 1, result valid.
- local_HWS_done_ready, in, 1, result accepted.
- HWS_local_busy, out, 1, high in any state other than IDLE.

Function
REQ-003 The block SHALL instantiate exactly one BitCounter with WID_CountRange=WID_Chunk and WID_CountResult=$clog2(WID_Chunk)+1, driven by local_HWS_chunk.
REQ-004 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-005 IDLE: start=1 -> RUN; clear the accumulator, the chunk index and pc_vld; latch the threshold.
REQ-006 RUN: chunk_ready=1; a chunk is accepted when valid&ready. On acceptance, register the BitCounter result into pc_q, set pc_vld=1, and increment the chunk index. Otherwise pc_vld=0.
REQ-007 RUN: acceptance of chunk index NUM_Chunks-1 -> DRAIN; the chunk index is 0..NUM_Chunks-1 with no wrap inside a frame.
REQ-008 Accumulator: acc <= acc + pc_q in every cycle where pc_vld=1, in any state. The addition is zero-extended to WID_Total and SHALL never overflow.
REQ-009 DRAIN: chunk_ready=0; one cycle, then -> DONE unconditionally.
REQ-010 Latency: last chunk accepted in cycle T -> done_valid=1 in cycle T+2.
REQ-011 DONE: done_valid=1, weight=acc, over=(acc > threshold) as an unsigned compare. These outputs SHALL be held stable until done_ready=1, then -> IDLE in the next cycle.
REQ-012 chunk_ready SHALL be 0 outside RUN; chunk_valid outside RUN SHALL be ignored, with no state change.
REQ-013 start outside IDLE SHALL be ignored and not queued, including start coincident with the done handshake in DONE.
REQ-014 Valid gaps in RUN SHALL stall without loss; no timeout.
REQ-015 With NUM_Chunks=1, the first acceptance SHALL go directly to DRAIN.
REQ-016 weight and over SHALL read 0 whenever done_valid=0.

Reset
REQ-017 rst=1 at a clock edge SHALL force, in any state including mid-frame: state=IDLE, acc=0, chunk index=0, pc_q=0, pc_vld=0, latched threshold=0.
REQ-018 Reset values of outputs: chunk_ready=0, done_valid=0, weight=0, over=0, busy=0. rst SHALL dominate start, chunk_valid and done_ready in the same cycle.
REQ-019 A frame interrupted by rst SHALL be discarded; the next frame counts only its own chunks.

Verification
REQ-020 Reset: hold rst for 3 cycles with random inputs -> all outputs 0; start in the reset cycle is ignored.
REQ-021 Full frame: defaults, threshold=255, 8 chunks of 0xFFFFFFFF back-to-back -> weight=256, over=1, done_valid exactly 2 cycles after the 8th accept.
REQ-022 Gapped input: threshold=32, 8 chunks of 0x0000000F with 1-3 idle cycles between chunks -> weight=32, over=0 (equal is not over).
REQ-023 Result backpressure: done_ready low for 5 cycles, start pulsed during DONE -> weight, over and done_valid stable; start ignored; IDLE one cycle after done_ready; busy=0.
REQ-024 Mid-frame reset: 3 chunks of 0xFFFFFFFF, then rst, then a new frame of 8 chunks of 0x00000001 -> weight=8.
REQ-025 NUM_Chunks=1: one chunk of 0x80000001, threshold=1 -> weight=2, over=1, done_valid 2 cycles after accept.
